food_placer: RTL

- Consumes the pixel-coordinate candidates from the random coordinate generator (randNumX/randNumY, 25-px grid, +2 offset).
- Rejects candidates that fall outside the playfield or land on the snake body, using a request/acknowledge query to the body tracker.
- Holds the accepted food position for the renderer.
- On each game step, detects the head eating the food, pulses eaten, bumps the score and re-places the food.

---
 rtl/food_placer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/food_placer.sv
// Food placement for the snake game: draws grid candidates, rejects off-field or
// body-occupied cells via the body tracker, and re-places food each time it is eaten.
module food_placer #(
   parameter int unsigned GRID        = 25,
   parameter int unsigned OFFSET      = 2,
   parameter int unsigned MAX_X       = OFFSET + 24 * GRID,
   parameter int unsigned MAX_Y       = OFFSET + 18 * GRID,
   parameter int unsigned RETRY_LIMIT = 16,
   parameter int unsigned FALLBACK_X  = OFFSET + 12 * GRID,
   parameter int unsigned FALLBACK_Y  = OFFSET + 9 * GRID,
   parameter int unsigned SCORE_W     = 8
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               restart,
   input  logic               step,
   input  logic [9:0]         head_x,
   input  logic [9:0]         head_y,
   input  logic [9:0]         randNumX,
   input  logic [9:0]         randNumY,
   output logic               occ_req,
   output logic [9:0]         occ_x,
   output logic [9:0]         occ_y,
   input  logic               occ_ack,
   input  logic               occ_hit,
   output logic [9:0]         food_x,
   output logic [9:0]         food_y,
   output logic               food_valid,
   output logic               eaten,
   output logic [SCORE_W-1:0] score
);

   localparam int unsigned CW = 10;
   localparam int unsigned RW = $clog2(RETRY_LIMIT + 1);

   typedef enum logic [1:0] {SAMPLE, BOUNDS, QUERY, PLACED} state_t;

   state_t             state, stateNext;
   logic [CW-1:0]      candX, candXNext, candY, candYNext;
   logic [CW-1:0]      occXNext, occYNext, foodXNext, foodYNext;
   logic               occReqNext, foodValidNext, eatenNext, reject;
   logic [RW-1:0]      retry, retryNext, retryInc;
   logic [SCORE_W-1:0] scoreNext;

   assign retryInc = retry + RW'(1);

   // Next-state and next-output logic; restart overrides every state.
   always_comb begin
      stateNext     = state;
      candXNext     = candX;
      candYNext     = candY;
      occReqNext    = occ_req;
      occXNext      = occ_x;
      occYNext      = occ_y;
      foodXNext     = food_x;
      foodYNext     = food_y;
      foodValidNext = food_valid;
      eatenNext     = 1'b0;
      scoreNext     = score;
      retryNext     = retry;
      reject        = 1'b0;

      if (restart) begin
         stateNext     = SAMPLE;
         scoreNext     = '0;
         foodValidNext = 1'b0;
         occReqNext    = 1'b0;
         retryNext     = '0;
      end else begin
         case (state)
            SAMPLE: begin
               candXNext = randNumX;
               candYNext = randNumY;
               stateNext = BOUNDS;
            end
            BOUNDS: begin
               if (candX > CW'(MAX_X) || candY > CW'(MAX_Y)) begin
                  reject = 1'b1;
               end else begin
                  occReqNext = 1'b1;
                  occXNext   = candX;
                  occYNext   = candY;
                  stateNext  = QUERY;
               end
            end
            QUERY: begin
               if (occ_ack) begin
                  occReqNext = 1'b0;
                  if (occ_hit) begin
                     reject = 1'b1;
                  end else begin
                     foodXNext     = candX;
                     foodYNext     = candY;
                     foodValidNext = 1'b1;
                     retryNext     = '0;
                     stateNext     = PLACED;
                  end
               end
            end
            PLACED: begin
               if (step && head_x == food_x && head_y == food_y) begin
                  eatenNext     = 1'b1;
                  scoreNext     = (score == '1) ? score : score + SCORE_W'(1);
                  foodValidNext = 1'b0;
                  stateNext     = SAMPLE;
               end
            end
            default: stateNext = SAMPLE;
         endcase

         // Too many rejections: drop food at the fixed fallback cell unqueried.
         if (reject) begin
            if (retryInc == RW'(RETRY_LIMIT)) begin
               foodXNext     = CW'(FALLBACK_X);
               foodYNext     = CW'(FALLBACK_Y);
               foodValidNext = 1'b1;
               retryNext     = '0;
               stateNext     = PLACED;
            end else begin
               retryNext = retryInc;
               stateNext = SAMPLE;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= SAMPLE;
         candX      <= '0;
         candY      <= '0;
         occ_req    <= 1'b0;
         occ_x      <= '0;
         occ_y      <= '0;
         food_x     <= '0;
         food_y     <= '0;
         food_valid <= 1'b0;
         eaten      <= 1'b0;
         score      <= '0;
         retry      <= '0;
      end else begin
         state      <= stateNext;
         candX      <= candXNext;
         candY      <= candYNext;
         occ_req    <= occReqNext;
         occ_x      <= occXNext;
         occ_y      <= occYNext;
         food_x     <= foodXNext;
         food_y     <= foodYNext;
         food_valid <= foodValidNext;
         eaten      <= eatenNext;
         score      <= scoreNext;
         retry      <= retryNext;
      end
   end

endmodule
